pc_sw_debounce: RTL and testbench
=================================

PC_SW_DEBOUNCE -- requirements
Module: pc_sw_debounce

Interface
REQ-001 SHALL have parameter W, default 7, the width of the switch vector feeding the 7:3 parallel counter.
REQ-002 SHALL have parameter DEB_CYCLES, default 1000000, the number of stable clk cycles required to accept a bit change (10 ms at 100 MHz); legal range 1 to 2^24.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sw_in  input  W  raw asynchronous switch levels (SW[W-1:0]).
REQ-006 SHALL have port d  output  W  debounced switch vector, registered, driving the parallel counter input.
REQ-007 SHALL have port d_valid  output  1  one-cycle pulse marking the cycle in which d takes a new value.
REQ-008 SHALL have port chg_cnt  output  8  count of d_valid pulses since reset.

Function
REQ-009 SHALL pass each sw_in bit through a two-flop synchronizer (sync1, then sync2) before any other logic uses it.
REQ-010 SHALL keep one independent debounce counter per bit, width ceil(log2(DEB_CYCLES)), minimum 1 bit.
REQ-011 SHALL, per bit on each edge, when sync2 equals d: clear that bit's counter to 0.
REQ-012 SHALL, per bit on each edge, when sync2 differs from d and the counter is below DEB_CYCLES-1: increment the counter.
REQ-013 SHALL, per bit on each edge, when sync2 differs from d and the counter equals DEB_CYCLES-1: load sync2 into d and clear the counter.
REQ-014 SHALL give this latency: if sw_in changes before edge k and then holds, d updates at edge k+1+DEB_CYCLES.
REQ-015 SHALL restart the stable-cycle count from 0 on any glitch: sync2 returning to d for one cycle clears the counter.
REQ-016 SHALL drive d_valid high for exactly the one cycle after any edge on which at least one bit of d changed, and low otherwise.
REQ-017 SHALL produce a single d_valid pulse when several bits of d change on the same edge.
REQ-018 SHALL increment chg_cnt by 1 on each edge that asserts d_valid, wrapping from 255 to 0.
REQ-019 SHALL, with DEB_CYCLES=1, accept a change on the first edge at which sync2 differs from d, with no extra cycle.
REQ-020 SHALL have no combinational path from sw_in to any output.

Reset
REQ-021 SHALL, while rst_n is low, clear sync1, sync2, all debounce counters, d, d_valid and chg_cnt to 0, independent of clk.
REQ-022 SHALL, on rst_n assertion in the middle of a debounce, discard the partial count; after release, a held input needs the full 2+DEB_CYCLES edges to reach d.
REQ-023 SHALL, when sw_in is nonzero at reset release, treat it as a normal change from 0: d updates after the full latency, with one d_valid pulse.

Verification (DEB_CYCLES=4, W=7)
REQ-024 SHALL cover: reset, then sw_in 0000000 -> 0000101 held before edge k -> d=0000101 at edge k+5, d_valid high for one cycle, chg_cnt=1.
REQ-025 SHALL cover: sw_in bit0 toggles every 2 cycles for 40 cycles -> d unchanged, d_valid never asserted, chg_cnt unchanged.
REQ-026 SHALL cover: bits 6 and 0 change on the same edge and hold -> both update on the same edge, one d_valid pulse, chg_cnt +1.
REQ-027 SHALL cover: bit3 changes, then bit5 changes 2 cycles later -> two separate d_valid pulses 2 cycles apart, chg_cnt +2.
REQ-028 SHALL cover: 256 accepted changes -> chg_cnt reads 0 after the 256th pulse.
REQ-029 SHALL cover: rst_n pulsed low mid-debounce, with sw_in=1111111 held -> outputs cleared immediately; d=1111111 exactly 6 edges after release.

Source files
------------

// File: rtl/pc_sw_debounce.sv
// Per-bit switch debouncer that feeds the 7:3 parallel counter.
// Each bit is synchronized, then accepted only after DEB_CYCLES stable cycles.
module pc_sw_debounce #(
    parameter int W          = 7,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw_in,
    output logic [W-1:0] d,
    output logic         d_valid,
    output logic [7:0]   chg_cnt
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [W-1:0]  sync1_q;
    logic [W-1:0]  sync2_q;
    logic [CW-1:0] cnt_q [W];
    logic [CW-1:0] cnt_d [W];
    logic [W-1:0]  d_q;
    logic [W-1:0]  d_d;
    logic          d_valid_q;
    logic          d_valid_d;
    logic [7:0]    chg_cnt_q;
    logic [7:0]    chg_cnt_d;

    // Per-bit stability counters; a bit is loaded only on its final stable cycle.
    always_comb begin
        d_d = d_q;
        for (int i = 0; i < W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == d_q[i]) begin
                cnt_d[i] = {CW{1'b0}};
            end else if (cnt_q[i] == CNT_MAX) begin
                d_d[i]   = sync2_q[i];
                cnt_d[i] = {CW{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + {{(CW-1){1'b0}}, 1'b1};
            end
        end
        d_valid_d = (d_d != d_q);
        if (d_valid_d) begin
            chg_cnt_d = chg_cnt_q + 8'd1;
        end else begin
            chg_cnt_d = chg_cnt_q;
        end
    end

    // Synchronizer, debounce counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= {W{1'b0}};
            sync2_q   <= {W{1'b0}};
            d_q       <= {W{1'b0}};
            d_valid_q <= 1'b0;
            chg_cnt_q <= 8'd0;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            sync1_q   <= sw_in;
            sync2_q   <= sync1_q;
            d_q       <= d_d;
            d_valid_q <= d_valid_d;
            chg_cnt_q <= chg_cnt_d;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign d       = d_q;
    assign d_valid = d_valid_q;
    assign chg_cnt = chg_cnt_q;

endmodule

// File: tb/tb_pc_sw_debounce.sv
// Directed bench for pc_sw_debounce with DEB_CYCLES=4 (plus a DEB_CYCLES=1 instance).
module tb_pc_sw_debounce;

    logic       clk;
    logic       rst_n;
    logic [6:0] sw_in;
    logic [6:0] d;
    logic       d_valid;
    logic [7:0] chg_cnt;
    logic [6:0] d1;
    logic       d_valid1;
    logic [7:0] chg_cnt1;

    int checks   = 0;
    int failures = 0;
    int dv_seen;
    logic [7:0] exp_chg;

    pc_sw_debounce #(.W(7), .DEB_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
        .d(d), .d_valid(d_valid), .chg_cnt(chg_cnt)
    );

    pc_sw_debounce #(.W(7), .DEB_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
        .d(d1), .d_valid(d_valid1), .chg_cnt(chg_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw_in = 7'b0000000;
        tick(2);
        chk("reset_d", 32'(d), 32'h0);
        chk("reset_dv", 32'(d_valid), 32'h0);
        chk("reset_cnt", 32'(chg_cnt), 32'h0);
        rst_n = 1'b1;
        tick(3);

        // Basic acceptance: change before edge k, d at k+5 (k+2 for DEB_CYCLES=1)
        sw_in = 7'b0000101;
        tick(1);
        chk("deb1_k", 32'(d1), 32'h0);
        tick(1);
        chk("deb1_k1", 32'(d1), 32'h0);
        tick(1);
        chk("deb1_k2", 32'(d1), 32'h05);
        chk("deb1_dv", 32'(d_valid1), 32'h1);
        tick(2);
        chk("basic_k4_d", 32'(d), 32'h0);
        chk("basic_k4_dv", 32'(d_valid), 32'h0);
        tick(1);
        chk("basic_k5_d", 32'(d), 32'h05);
        chk("basic_k5_dv", 32'(d_valid), 32'h1);
        chk("basic_k5_cnt", 32'(chg_cnt), 32'h1);
        tick(1);
        chk("basic_k6_dv", 32'(d_valid), 32'h0);
        chk("basic_k6_cnt", 32'(chg_cnt), 32'h1);

        // Bit0 toggling every 2 cycles never reaches the stable count
        dv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            sw_in[0] = ~sw_in[0];
            for (int j = 0; j < 2; j++) begin
                tick(1);
                if (d_valid) dv_seen++;
            end
        end
        tick(8);
        for (int j = 0; j < 8; j++) if (d_valid) dv_seen++;
        chk("glitch_dv_seen", 32'(dv_seen), 32'h0);
        chk("glitch_d", 32'(d), 32'h05);
        chk("glitch_cnt", 32'(chg_cnt), 32'h1);

        // Bits 6 and 0 change together: one pulse
        sw_in = 7'b1000100;
        tick(5);
        chk("multi_k4_d", 32'(d), 32'h05);
        tick(1);
        chk("multi_k5_d", 32'(d), 32'h44);
        chk("multi_k5_dv", 32'(d_valid), 32'h1);
        chk("multi_k5_cnt", 32'(chg_cnt), 32'h2);
        tick(1);
        chk("multi_k6_dv", 32'(d_valid), 32'h0);
        chk("multi_k6_cnt", 32'(chg_cnt), 32'h2);

        // Bit3 then bit5 two cycles later: two pulses two cycles apart
        sw_in = 7'b1001100;
        tick(2);
        sw_in = 7'b1101100;
        tick(3);
        chk("stag_k4_d", 32'(d), 32'h44);
        chk("stag_k4_dv", 32'(d_valid), 32'h0);
        tick(1);
        chk("stag_k5_d", 32'(d), 32'h4c);
        chk("stag_k5_dv", 32'(d_valid), 32'h1);
        chk("stag_k5_cnt", 32'(chg_cnt), 32'h3);
        tick(1);
        chk("stag_k6_dv", 32'(d_valid), 32'h0);
        tick(1);
        chk("stag_k7_d", 32'(d), 32'h6c);
        chk("stag_k7_dv", 32'(d_valid), 32'h1);
        chk("stag_k7_cnt", 32'(chg_cnt), 32'h4);
        tick(1);
        chk("stag_k8_dv", 32'(d_valid), 32'h0);

        // Drive the change counter to 256 pulses since reset
        exp_chg = 8'd4;
        for (int i = 0; i < 251; i++) begin
            sw_in[1] = ~sw_in[1];
            tick(7);
            exp_chg = exp_chg + 8'd1;
        end
        chk("wrap_pre_cnt", 32'(chg_cnt), 32'(exp_chg));
        chk("wrap_pre_d", 32'(d), 32'h6e);
        sw_in[1] = ~sw_in[1];
        tick(6);
        chk("wrap_dv", 32'(d_valid), 32'h1);
        chk("wrap_cnt", 32'(chg_cnt), 32'h0);
        chk("wrap_d", 32'(d), 32'h6c);
        tick(2);

        // Reset in the middle of a debounce with all switches set
        sw_in = 7'b1111111;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_d", 32'(d), 32'h0);
        chk("midrst_dv", 32'(d_valid), 32'h0);
        chk("midrst_cnt", 32'(chg_cnt), 32'h0);
        tick(2);
        chk("midrst_hold_d", 32'(d), 32'h0);
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_e5_d", 32'(d), 32'h0);
        chk("post_rst_e5_dv", 32'(d_valid), 32'h0);
        tick(1);
        chk("post_rst_e6_d", 32'(d), 32'h7f);
        chk("post_rst_e6_dv", 32'(d_valid), 32'h1);
        chk("post_rst_e6_cnt", 32'(chg_cnt), 32'h1);
        tick(1);
        chk("post_rst_e7_dv", 32'(d_valid), 32'h0);
        chk("post_rst_e7_cnt", 32'(chg_cnt), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
